// File: rtl/seq_addsub_16b_if.sv
// Handshake and operand/result bundle for the nibble-serial 16-bit adder/subtractor.
// The requester uses the master modport; seq_addsub_16b uses the slave modport.
interface seq_addsub_16b_if;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        c_out;
    logic        ovf;

    modport master (
        output start, sub, a, b,
        input  ready, done, result, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output ready, done, result, c_out, ovf
    );
endinterface

// File: rtl/seq_addsub_16b.sv
// Nibble-serial 16-bit add/subtract: one 4-bit slice reused over four RUN cycles.
// Optional signed-overflow flag is built only when SEQ_ADDSUB_OVF_EN is defined.
module seq_addsub_16b (
    input logic             clk,
    input logic             rst_n,
    seq_addsub_16b_if.slave bus
);
    localparam int DATA_W  = 16;
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W-1:0]   result_q;
    logic                carry;
    logic                c_out_q;
    logic [1:0]          k;
    logic [SLICE_W-1:0]  nib_a;
    logic [SLICE_W-1:0]  nib_b;
    logic [SLICE_W-1:0]  nib_s;
    logic                nib_c;
    logic                accept;
    logic                last;

    function automatic logic [SLICE_W:0] slice_add(input logic [SLICE_W-1:0] x,
                                                   input logic [SLICE_W-1:0] y,
                                                   input logic               cin);
        slice_add = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, cin};
    endfunction

    assign nib_a            = op_a[{k, 2'b00} +: SLICE_W];
    assign nib_b            = op_b[{k, 2'b00} +: SLICE_W];
    assign {nib_c, nib_s}   = slice_add(nib_a, nib_b, carry);
    assign accept           = (state_q == IDLE) && bus.start;
    assign last             = (state_q == RUN) && (k == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (k == 2'd3) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state_q == IDLE);
        bus.done  = (state_q == DONE);
    end

    // Subtraction is a + ~b + 1: the +1 enters as the initial slice carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            k        <= 2'd0;
            result_q <= '0;
            c_out_q  <= 1'b0;
        end else if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.b ^ {DATA_W{bus.sub}};
            carry <= bus.sub;
            k     <= 2'd0;
        end else if (state_q == RUN) begin
            result_q[{k, 2'b00} +: SLICE_W] <= nib_s;
            carry                           <= nib_c;
            k                               <= k + 2'd1;
            if (last) begin
                c_out_q <= nib_c;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;

`ifdef SEQ_ADDSUB_OVF_EN
    logic ovf_q;
    logic c_into_msb;

    // Carry into bit 15 is the carry out of the low three bits of the top slice.
    function automatic logic msb_carry_in(input logic [SLICE_W-1:0] x,
                                          input logic [SLICE_W-1:0] y,
                                          input logic               cin);
        logic [SLICE_W-1:0] t;
        t = {1'b0, x[SLICE_W-2:0]} + {1'b0, y[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};
        msb_carry_in = t[SLICE_W-1];
    endfunction

    assign c_into_msb = msb_carry_in(nib_a, nib_b, carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= c_into_msb ^ nib_c;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: doc/seq_addsub_16b.md
# seq_addsub_16b

Nibble-serial 16-bit adder/subtractor. It reuses a single 4-bit add slice over four clock cycles to compute `a + b` or `a - b`, with a start/ready/done handshake. It sits beside the combinational 16-bit ripple-carry adder in the datapath as its area-reduced, multi-cycle counterpart. It also adds the subtract direction, implemented as two's-complement with borrow reported through `c_out`.

## Interface
Parameters:
- none (width fixed at 16 bits, slice fixed at 4 bits)

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `start`  input  1  request a new operation; sampled only while `ready`=1
- `sub`  input  1  0 = add, 1 = subtract; sampled with `start`
- `a`  input  16  first operand; sampled with `start`
- `b`  input  16  second operand; sampled with `start`
- `ready`  output  1  high when IDLE and able to accept `start`
- `done`  output  1  one-cycle pulse; `result`/`c_out`/`ovf` valid
- `result`  output  16  sum or difference
- `c_out`  output  1  add: carry out of bit 15; sub: 1 = no borrow (a >= b unsigned), 0 = borrow
- `ovf`  output  1  signed overflow (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `ready`=1.
  - When `start`=1 at an edge, latch `A`=a and `B`=b ^ {16{sub}`}`, set carry register `c`=sub, nibble counter `k`=0, go to RUN.
- RUN, at each edge:
  - Compute {c', s} = A[4k+3:4k] + B[4k+3:4k] + c.
  - Write s into `result[4k+3:4k]` and set c=c'.
  - k increments (2-bit counter).
  - On the edge where k=3, also load `c_out`=c' and `ovf`, then go to DONE.
- DONE: `done`=1 for exactly one cycle; the next edge goes to IDLE unconditionally.
- `start` outside IDLE is ignored; it is neither queued nor able to corrupt the operation in flight. `a`/`b`/`sub` may change freely after acceptance.
- `result`, `c_out` and `ovf` hold their last values from DONE through IDLE. `result` nibbles are overwritten progressively during the next RUN, so they are valid only while `done`=1 or in IDLE after a completed op.
- Arithmetic is modulo 2^16; no saturation.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, `ready`=1, `done`=0, `result`=16'h0000, `c_out`=0, `ovf`=0, internal `A`/`B`/`c`/`k` cleared.
- Reset mid-RUN or mid-DONE aborts the operation with no `done` pulse.
- Let edge E0 be the edge at which `start` is accepted:
  - edges E1..E4 compute nibbles 0..3;
  - `done`=1 in the cycle after E4;
  - `ready`=1 again after E5.
- Latency is 5 cycles from acceptance to `done`. Throughput is one op per 6 cycles.
- `start` held high continuously re-triggers at every IDLE cycle: one accept per 6 cycles.
- `ready` and `done` are never high in the same cycle.

## Configuration
- Macro: `SEQ_ADDSUB_OVF_EN`.
- Defined:
  - `ovf` is loaded on the final RUN edge with carry-into-bit-15 XOR carry-out-of-bit-15.
  - Carry-into-bit-15 is computed from the k=3 slice inputs, i.e. the bit-14 carry inside the slice.
  - `ovf` holds its value like `result`.
- Not defined: the overflow logic is compiled out and `ovf` is tied to constant 0 from reset onward. The port remains present so instantiations do not change.

## Test plan
- Add 16'h1234 + 16'h4321: `done` is 5 cycles after acceptance, with `result`=16'h5555, `c_out`=0, `ovf`=0. `ready` is low on E1..E5 and high after.
- Add 16'hFFFF + 16'h0001: `result`=16'h0000, `c_out`=1, `ovf`=0. This checks carry ripple through all four nibbles.
- Sub 16'h0005 - 16'h0007: `result`=16'hFFFE, `c_out`=0 (borrow). Sub 16'h0007 - 16'h0005: `result`=16'h0002, `c_out`=1.
- Add 16'h7FFF + 16'h0001 gives `result`=16'h8000, with `ovf`=1 when `SEQ_ADDSUB_OVF_EN` is defined and 0 otherwise. Sub 16'h8000 - 16'h0001 gives `result`=16'h7FFF, `c_out`=1, with `ovf`=1 when defined.
- Pulse `start` with new operands (16'hAAAA, 16'h5555) during RUN: the ignored request does not alter the in-flight result. Then assert `rst_n`=0 at E2 of a new op: `result`=0, `ready`=1, and no `done` pulse follows.
